// File: rtl/dlx_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dlx_ctrl_pkg : state encoding and stage-enable helpers shared by |
// |                the DLX multicycle control path.                  |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
package dlx_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RST  = 3'd0,
        ST_IF   = 3'd1,
        ST_ID   = 3'd2,
        ST_EX   = 3'd3,
        ST_MEM  = 3'd4,
        ST_WB   = 3'd5,
        ST_HALT = 3'd6,
        ST_ERR  = 3'd7
    } state_t;

    typedef struct packed {
        logic if_en;
        logic id_en;
        logic ex_en;
        logic mem_en;
        logic wb_en;
    } stage_en_t;

    function automatic stage_en_t stage_decode(input state_t s);
        stage_en_t en;
        en = '0;
        case (s)
            ST_IF:   en.if_en  = 1'b1;
            ST_ID:   en.id_en  = 1'b1;
            ST_EX:   en.ex_en  = 1'b1;
            ST_MEM:  en.mem_en = 1'b1;
            ST_WB:   en.wb_en  = 1'b1;
            default: en = '0;
        endcase
        return en;
    endfunction

    // Every path back into fetch passes through here so a pending halt is honoured.
    function automatic state_t if_entry(input logic halt_req);
        return halt_req ? ST_HALT : ST_IF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dlx_wait_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dlx_wait_timer : counts unacknowledged memory request cycles and |
// |                  flags a timeout; TIMEOUT=0 disables it.         |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module dlx_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    input  logic ack,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            logic unused_inputs;
            assign unused_inputs = ^{clk, reset, clear, count_en, ack};
            assign expired       = 1'b0;
        end else begin : g_timeout
            localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clear) begin
                    cnt_d = '0;
                end else if (count_en && !ack && (cnt_q != LIMIT)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            // An ack on the limit cycle suppresses expiry.
            assign expired = count_en && !ack && (cnt_q == LIMIT);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/dlx_stage_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dlx_stage_sequencer : multicycle IF/ID/EX/MEM/WB control FSM     |
// |                       with memory handshakes, halt and timeout.  |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module dlx_stage_sequencer
    import dlx_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             halt_req,
    input  logic             i_ack,
    input  logic             d_ack,
    input  logic             d_load_enable,
    input  logic             d_write_enable,
    output logic             IF,
    output logic             ID,
    output logic             EX,
    output logic             MEM,
    output logic             WB,
    output logic             i_req,
    output logic             d_req,
    output logic             d_we,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    state_t           state_q, state_d;
    logic             load_q, load_d;
    logic             store_q, store_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;
    logic             wait_clear, wait_count, wait_ack, wait_expired;
    stage_en_t        stage;

    assign wait_count = (state_q == ST_IF) || (state_q == ST_MEM);
    assign wait_ack   = (state_q == ST_IF) ? i_ack : d_ack;
    assign wait_clear = (state_d != state_q) &&
                        ((state_d == ST_IF) || (state_d == ST_MEM));

    dlx_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (wait_clear),
        .count_en (wait_count),
        .ack      (wait_ack),
        .expired  (wait_expired)
    );

    always_comb begin
        state_d = state_q;
        load_d  = load_q;
        store_d = store_q;
        case (state_q)
            ST_RST: state_d = if_entry(halt_req);
            ST_IF: begin
                if (i_ack) begin
                    state_d = ST_ID;
                end else if (wait_expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_ID: state_d = ST_EX;
            ST_EX: begin
                load_d  = d_load_enable;
                store_d = d_write_enable;
                if (d_load_enable && d_write_enable) begin
                    state_d = ST_ERR;
                end else if (d_load_enable || d_write_enable) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (d_ack) begin
                    if (store_q) begin
                        state_d = if_entry(halt_req);
                    end else if (load_q) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else if (wait_expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_WB:   state_d = if_entry(halt_req);
            ST_HALT: if (!halt_req) state_d = ST_IF;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
    end

    // Stores retire on their data ack; everything else retires in WB.
    assign retire    = (state_q == ST_WB) || ((state_q == ST_MEM) && d_ack && store_q);
    assign retired_d = retire ? (retired_q + CNT_W'(1)) : retired_q;
    assign error_d   = error_q || (state_d == ST_ERR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RST;
            load_q    <= 1'b0;
            store_q   <= 1'b0;
            error_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            load_q    <= load_d;
            store_q   <= store_d;
            error_q   <= error_d;
            retired_q <= retired_d;
        end
    end

    assign stage   = stage_decode(state_q);
    assign IF      = stage.if_en;
    assign ID      = stage.id_en;
    assign EX      = stage.ex_en;
    assign MEM     = stage.mem_en;
    assign WB      = stage.wb_en;
    assign i_req   = (state_q == ST_IF);
    assign d_req   = (state_q == ST_MEM);
    assign d_we    = (state_q == ST_MEM) && store_q;
    assign halted  = (state_q == ST_HALT);
    assign error   = error_q;
    assign retired = retired_q;
    assign state   = state_q;

endmodule
`default_nettype wire

// File: doc/dlx_stage_sequencer.md
Name: dlx_stage_sequencer

Overview:
Multicycle control FSM for the DLX core. It sequences one instruction at a time through fetch, decode, execute, memory and write-back. It drives the one-hot stage enables consumed by the decoder, ALU, PC unit and register file. It handshakes with instruction and data memory, supports wait states, optional timeouts and an external halt, and counts retired instructions.

Parameters:
TIMEOUT, 16, max cycles a memory request may stay unacknowledged before error; 0 disables the timeout
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  synchronous reset, active-high
halt_req  in  1  request to stop before next fetch
i_ack  in  1  instruction memory read done; instruction word valid this cycle
d_ack  in  1  data memory access done
d_load_enable  in  1  from decoder: current instruction is a load
d_write_enable  in  1  from decoder: current instruction is a store
IF  out  1  fetch stage enable
ID  out  1  decode stage enable (drives decoder ID)
EX  out  1  execute stage enable
MEM  out  1  memory stage enable
WB  out  1  write-back stage enable
i_req  out  1  instruction read request
d_req  out  1  data access request
d_we  out  1  data access is a write (valid when d_req=1)
halted  out  1  FSM parked in HALT
error  out  1  sticky fault flag
retired  out  CNT_W  retired instruction count
state  out  3  encoded FSM state, for debug

Behaviour:
- Moore outputs decoded from the state register; retired and error are registers.
- States: RST, IF, ID, EX, MEM, WB, HALT, ERR.
- reset=1: next state RST, retired=0, error=0, wait counter=0. RST decodes all outputs to 0. Reset mid-instruction aborts it with no retire.
- RST -> IF-entry.
- IF-entry rule, applied on every transition into IF: if halt_req=1, go to HALT instead of IF.
- IF: IF=1, i_req=1. i_ack=1 -> ID. Otherwise stay in IF.
- ID: ID=1, one cycle, then EX.
- EX: EX=1, one cycle. Samples d_load_enable and d_write_enable:
  - both 1 -> ERR.
  - load -> MEM with a latched load flag.
  - store -> MEM with a latched store flag.
  - neither -> WB.
- MEM: MEM=1, d_req=1, d_we=latched store flag. d_ack=1:
  - load -> WB.
  - store -> IF-entry, and retired increments.
  - Otherwise stay in MEM.
- WB: WB=1, one cycle. retired increments, then IF-entry.
- Instruction latencies, with ack in the first request cycle:
  - ALU/branch: 4 cycles.
  - store: 4 cycles.
  - load: 5 cycles.
- Wait counter:
  - Cleared on entry to IF or MEM.
  - Increments each cycle the request is unacknowledged.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no ack this cycle, next state is ERR.
  - An ack arriving in the same cycle as the limit wins: normal transition.
- HALT: halted=1, all enables and requests 0. halt_req=0 -> IF.
- ERR: error set (sticky), all enables 0, halted=0. Exit only via reset.
- retired wraps modulo 2^CNT_W.
- Exactly one of IF/ID/EX/MEM/WB is high outside RST, HALT and ERR.
- i_ack in a non-IF state and d_ack in a non-MEM state are ignored.
- halt_req during an instruction has no effect until the next IF-entry.

Decomposition:
- Package dlx_ctrl_pkg holds:
  - state_t enum: RST=0, IF=1, ID=2, EX=3, MEM=4, WB=5, HALT=6, ERR=7.
  - Stage-enable struct type.
- Sub-module dlx_wait_timer: wait counter plus timeout compare, with inputs clear, count_en, ack and outputs expired. All other logic is a single FSM.

Test Plan:
- ALU instruction: reset for 2 cycles, then i_ack=1 in the first IF cycle, loads=0 in EX -> states IF,ID,EX,WB,IF; WB high exactly 1 cycle; retired 0->1.
- Load with wait states: d_load_enable=1 in EX, d_ack on the 3rd MEM cycle -> MEM and d_req high for 3 cycles, d_we=0, then WB; retired=1.
- Store: d_write_enable=1, d_ack in the first MEM cycle -> MEM, d_we=1 for 1 cycle, then IF with no WB; retired increments.
- Timeout: TIMEOUT=4, i_ack held 0 -> IF for 4 cycles, then ERR; error=1 stays set until reset, after which state=RST and error=0.
- Halt: assert halt_req during EX of an ALU instruction -> instruction completes through WB, then HALT (halted=1). Deassert halt_req -> IF next cycle.
- Illegal and abort cases:
  - d_load_enable=d_write_enable=1 in EX -> ERR.
  - reset asserted while in MEM -> RST next cycle, retired=0, d_req=0.
